uart_sample_scheduler: RTL
==========================

UART_SAMPLE_SCHEDULER -- requirements
Module: uart_sample_scheduler

Interface
REQ-001 Parameter W, default 16, sample width in bits.
REQ-002 Parameter DECIM, default 16, range 1..256, sample_clk rising edges per snapshot.
REQ-003 clk  in  1  system clock (12 MHz).
REQ-004 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-005 sample_clk  in  1  codec sample clock level, synchronous to clk.
REQ-006 sample_in0..sample_in3  in  W each  signed calibrated samples.
REQ-007 ch_mask  in  4  channel enable; bit n enables channel n.
REQ-008 tx_busy  in  1  uart_tx busy flag.
REQ-009 tx_start  out  1  one-cycle byte-launch strobe to uart_tx.
REQ-010 tx_data  out  8  byte to transmit; valid while tx_start is high.
REQ-011 frame_done  out  1  one-cycle pulse when a snapshot frame completes.
REQ-012 overrun_cnt  out  8  saturating count of dropped snapshots.

Function
REQ-013 Rising edge of sample_clk SHALL be detected by comparing it with a registered copy; one edge increments the decimation counter.
REQ-014 The decimation counter SHALL wrap from DECIM-1 to 0; each wrap is a snapshot trigger (DECIM=1: every edge triggers).
REQ-015 On a trigger in IDLE, sample_in0..3 and ch_mask SHALL be latched in the same cycle; inputs changing afterwards SHALL NOT affect the frame.
REQ-016 On a trigger outside IDLE, no latch occurs and overrun_cnt SHALL increment, saturating at 255.
REQ-017 FSM states SHALL be IDLE, ISSUE, GUARD, WAIT.
REQ-018 IDLE -> ISSUE on accepted trigger; if the latched mask is 0, SHALL instead pulse frame_done the next cycle and stay in IDLE.
REQ-019 ISSUE: when tx_busy=0, SHALL drive tx_start=1 for exactly one cycle with tx_data, then enter GUARD; while tx_busy=1, SHALL hold with tx_start=0.
REQ-020 GUARD SHALL last exactly one cycle, ignoring tx_busy, then enter WAIT.
REQ-021 WAIT: when tx_busy=0, SHALL advance to the next byte and enter ISSUE; after the final byte, SHALL pulse frame_done and enter IDLE.
REQ-022 Per enabled channel, ascending index, bytes SHALL be "C" (0x43), "H" (0x48), 0x30+n, sample[W-1:W-8], sample[W-9:W-16].
REQ-023 Disabled channels SHALL emit no bytes.
REQ-024 A trigger in the same cycle as the frame_done pulse SHALL count as an overrun.
REQ-025 At most one tx_start pulse per GUARD/WAIT cycle pair; tx_start SHALL never be high two consecutive cycles.

Reset
REQ-026 With rst_n=0 at a clk edge: state IDLE; tx_start, tx_data, frame_done, overrun_cnt, decimation counter and the sample_clk copy SHALL be 0.
REQ-027 Reset mid-frame SHALL abandon the frame without further tx_start; a byte already launched in uart_tx completes independently.
REQ-028 The first sample_clk rising edge after reset release SHALL count as decimation edge 1.

Configuration
REQ-029 Macro UART_SAMPLE_CHECKSUM_EN defined: after each channel's LSB, one extra byte SHALL be sent, equal to (0x30+n) XOR MSB XOR LSB (6 bytes per channel).
REQ-030 Macro UART_SAMPLE_CHECKSUM_EN undefined: frames SHALL be 5 bytes per channel and no checksum logic SHALL be synthesized.

Verification
REQ-031 DECIM=1, ch_mask=0001, sample_in0=0x1234, tx_busy idle -> bytes 43,48,30,12,34 then one frame_done pulse.
REQ-032 ch_mask=1010, in1=0x8001, in3=0x00FF -> 43,48,31,80,01,43,48,33,00,FF; channels 0 and 2 absent.
REQ-033 DECIM=4 -> exactly one frame per 4 sample_clk rising edges; overrun_cnt stays 0.
REQ-034 tx_busy held high for 10 cycles after each launch with triggers still arriving -> no byte lost; overrun_cnt increments once per dropped trigger, saturating at 255.
REQ-035 rst_n=0 during 3rd byte -> tx_start stays 0 and all outputs 0; next trigger starts a fresh frame at "C".
REQ-036 UART_SAMPLE_CHECKSUM_EN defined, mask=0001, in0=0x1234 -> 43,48,30,12,34,16.

Source files
------------

// File: rtl/uart_sample_scheduler.sv
// uart_sample_scheduler: decimates a codec sample clock and, on each snapshot
// trigger, serialises up to four latched channel samples to a byte UART as
// "C","H",'0'+n,MSB,LSB per enabled channel. Snapshots that arrive while a
// frame is still in flight are dropped and counted.
// Optional build macro UART_SAMPLE_CHECKSUM_EN appends a per-channel XOR byte.
module uart_sample_scheduler #(
  parameter int W     = 16,
  parameter int DECIM = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  input  logic [3:0]   ch_mask,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         frame_done,
  output logic [7:0]   overrun_cnt
);

`ifdef UART_SAMPLE_CHECKSUM_EN
  localparam int BPC = 6;
`else
  localparam int BPC = 5;
`endif
  localparam logic [2:0] LASTB = 3'(BPC - 1);
  // Counter is sized for the largest legal DECIM (256) so DECIM=1 needs no special case.
  localparam int CW = 9;
  localparam logic [CW-1:0] DLAST = CW'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

  state_t              state_q, state_d;
  logic                sclk_q;
  logic [CW-1:0]       dcnt_q, dcnt_d;
  logic [3:0][W-1:0]   smp_q, smp_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          ch_q, ch_d;
  logic [2:0]          bidx_q, bidx_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                done_q, done_d;
  logic [7:0]          ovr_q, ovr_d;

  logic                sedge, trig, accept;
  logic [W-1:0]        cur_smp;
  logic [7:0]          ch_chr, msb, lsb, byte_val;
  logic [2:0]          nxt;

  // Lowest enabled channel at or above 'from'; bit 2 flags that one exists.
  function automatic logic [2:0] first_en(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    return r;
  endfunction

  assign sedge  = sample_clk & ~sclk_q;
  assign trig   = sedge && (dcnt_q == DLAST);
  // The frame_done cycle still belongs to the finished frame, so a trigger there is dropped.
  assign accept = trig && (state_q == IDLE) && !done_q;

  // Byte for the current channel / byte position.
  always_comb begin
    cur_smp = smp_q[ch_q];
    ch_chr  = 8'h30 + {6'd0, ch_q};
    msb     = cur_smp[W-1 -: 8];
    lsb     = cur_smp[W-9 -: 8];
    case (bidx_q)
      3'd0:    byte_val = 8'h43;
      3'd1:    byte_val = 8'h48;
      3'd2:    byte_val = ch_chr;
      3'd3:    byte_val = msb;
      3'd4:    byte_val = lsb;
`ifdef UART_SAMPLE_CHECKSUM_EN
      3'd5:    byte_val = ch_chr ^ msb ^ lsb;
`endif
      default: byte_val = 8'h00;
    endcase
  end

  // Decimation, overrun counting, and the frame sequencing FSM.
  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    bidx_d     = bidx_q;
    tx_start_d = 1'b0;
    tx_data_d  = 8'h00;
    done_d     = 1'b0;
    nxt        = 3'b000;

    dcnt_d = dcnt_q;
    if (sedge) dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;

    ovr_d = ovr_q;
    if (trig && !accept && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          smp_d  = {sample_in3, sample_in2, sample_in1, sample_in0};
          mask_d = ch_mask;
          nxt    = first_en(ch_mask, 3'd0);
          if (nxt[2]) begin
            ch_d    = nxt[1:0];
            bidx_d  = 3'd0;
            state_d = ISSUE;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_val;
          state_d    = GUARD;
        end
      end
      // One dead cycle so uart_tx has time to raise busy for the byte just launched.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (bidx_q != LASTB) begin
            bidx_d  = bidx_q + 3'd1;
            state_d = ISSUE;
          end else begin
            nxt = first_en(mask_q, {1'b0, ch_q} + 3'd1);
            if (nxt[2]) begin
              ch_d    = nxt[1:0];
              bidx_d  = 3'd0;
              state_d = ISSUE;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      dcnt_q     <= '0;
      smp_q      <= '0;
      mask_q     <= 4'h0;
      ch_q       <= 2'd0;
      bidx_q     <= 3'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      ovr_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sample_clk;
      dcnt_q     <= dcnt_d;
      smp_q      <= smp_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      bidx_q     <= bidx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule
